// File: rtl/wb_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : wb_drain_sched
// Purpose  : Drains the five partial-sum row buffers onto the two write-back
//            ports after a filter pass. Rows (0,1) then (2,3) go out in
//            lockstep on port0/port1, then row 4 goes out alone on port0.
//            Passes are counted per output channel; all_done flags the last.
// Revision : 1.0 - initial release
// ============================================================================
module wb_drain_sched #(
    parameter int DATA_WIDTH = 25,
    parameter int OFM_W      = 8,
    parameter int OFM_C      = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] row0_data,
    input  logic [DATA_WIDTH-1:0] row1_data,
    input  logic [DATA_WIDTH-1:0] row2_data,
    input  logic [DATA_WIDTH-1:0] row3_data,
    input  logic [DATA_WIDTH-1:0] row4_data,
    input  logic                  row0_valid,
    input  logic                  row1_valid,
    input  logic                  row2_valid,
    input  logic                  row3_valid,
    input  logic                  row4_valid,
    output logic                  row0_pop,
    output logic                  row1_pop,
    output logic                  row2_pop,
    output logic                  row3_pop,
    output logic                  row4_pop,
    output logic [DATA_WIDTH-1:0] out_port0,
    output logic [DATA_WIDTH-1:0] out_port1,
    output logic                  port0_valid,
    output logic                  port1_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  pass_done,
    output logic                  all_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_P01  = 2'd1;
    localparam logic [1:0] S_P23  = 2'd2;
    localparam logic [1:0] S_R4   = 2'd3;

    localparam logic [CNT_WIDTH-1:0] C_COL_LAST  = CNT_WIDTH'(OFM_W - 1);
    localparam logic [CNT_WIDTH-1:0] C_CHAN_LAST = CNT_WIDTH'(OFM_C - 1);
    localparam logic [CNT_WIDTH-1:0] C_ONE       = CNT_WIDTH'(1);

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_col;
    logic [CNT_WIDTH-1:0]  r_chan;
    logic [DATA_WIDTH-1:0] r_out0;
    logic [DATA_WIDTH-1:0] r_out1;
    logic                  r_v0;
    logic                  r_v1;
    logic                  r_pass_done;
    logic                  r_all_done;

    logic w_accept;
    logic w_fire01;
    logic w_fire23;
    logic w_fire4;
    logic w_col_last;

    // Output slot is free when empty or being drained this cycle; a pair
    // fires only when both rows have a word, so rows never drift apart.
    always_comb begin
        w_accept   = !(r_v0 | r_v1) | out_ready;
        w_fire01   = !rst && (r_state == S_P01) && row0_valid && row1_valid && w_accept;
        w_fire23   = !rst && (r_state == S_P23) && row2_valid && row3_valid && w_accept;
        w_fire4    = !rst && (r_state == S_R4)  && row4_valid && w_accept;
        w_col_last = (r_col == C_COL_LAST);
    end

    assign row0_pop    = w_fire01;
    assign row1_pop    = w_fire01;
    assign row2_pop    = w_fire23;
    assign row3_pop    = w_fire23;
    assign row4_pop    = w_fire4;
    assign out_port0   = r_out0;
    assign out_port1   = r_out1;
    assign port0_valid = r_v0;
    assign port1_valid = r_v1;
    assign busy        = (r_state != S_IDLE);
    assign pass_done   = r_pass_done;
    assign all_done    = r_all_done;

    // Sequencer, column/channel counters and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_chan      <= '0;
            r_out0      <= '0;
            r_out1      <= '0;
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_pass_done <= 1'b0;
            r_all_done  <= 1'b0;
        end else begin
            r_pass_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_P01;
                        r_col      <= '0;
                        r_all_done <= 1'b0;
                    end
                end
                S_P01: begin
                    if (w_fire01) begin
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_state <= S_P23;
                        end else begin
                            r_col <= r_col + C_ONE;
                        end
                    end
                end
                S_P23: begin
                    if (w_fire23) begin
                        if (w_col_last) begin
                            r_col   <= '0;
                            r_state <= S_R4;
                        end else begin
                            r_col <= r_col + C_ONE;
                        end
                    end
                end
                default: begin
                    if (w_fire4) begin
                        if (w_col_last) begin
                            r_col       <= '0;
                            r_state     <= S_IDLE;
                            r_pass_done <= 1'b1;
                            if (r_chan == C_CHAN_LAST) begin
                                r_chan     <= '0;
                                r_all_done <= 1'b1;
                            end else begin
                                r_chan <= r_chan + C_ONE;
                            end
                        end else begin
                            r_col <= r_col + C_ONE;
                        end
                    end
                end
            endcase

            // Output registers load only on a pop; otherwise a consumed word
            // drops its valid, and a stalled word is held untouched.
            if (w_fire01) begin
                r_out0 <= row0_data;
                r_out1 <= row1_data;
                r_v0   <= 1'b1;
                r_v1   <= 1'b1;
            end else if (w_fire23) begin
                r_out0 <= row2_data;
                r_out1 <= row3_data;
                r_v0   <= 1'b1;
                r_v1   <= 1'b1;
            end else if (w_fire4) begin
                r_out0 <= row4_data;
                r_v0   <= 1'b1;
                r_v1   <= 1'b0;
            end else if (out_ready) begin
                r_v0 <= 1'b0;
                r_v1 <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_drain_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_drain_sched
// Purpose  : Self-checking bench for wb_drain_sched: row FIFO models, an
//            output scoreboard, a table of pass scenarios and hand-written
//            reset / single-column sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_drain_sched;

    localparam int DW = 25;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          v1;
    } exp_t;

    typedef struct {
        int   stall_at;
        int   stall_len;
        int   skew_at;
        int   skew_len;
        int   ign_start_at;
        int   exp_busy;
        logic exp_all;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, out_ready;
    logic [4:0]    en;
    logic [DW-1:0] mem [5][128];
    int unsigned   rd_ptr [5];
    int unsigned   wr_ptr [5];
    logic [DW-1:0] rd [5];
    logic [4:0]    rv;
    logic [4:0]    pop;
    logic [DW-1:0] out_port0, out_port1;
    logic          port0_valid, port1_valid, busy, pass_done, all_done;

    logic          w1_start;
    logic [DW-1:0] wd [5];
    logic [4:0]    w1_pop;
    logic [DW-1:0] w1_o0, w1_o1;
    logic          w1_v0, w1_v1, w1_busy, w1_pd, w1_ad;

    exp_t sb[$];
    vec_t vt [5];
    int   n_vec = 0, n_err = 0;
    int   words = 0, busy_cyc = 0, pd_cnt = 0, pass_no = 0;
    int   w1_fires = 0, w1_pdc = 0, w1_busyc = 0;
    logic [5:0]    w1_seq;
    logic [1:0]    w1_last;
    logic [4:0]    pop_l;
    logic          hold, hv1;
    logic [DW-1:0] hd0, hd1;

    // Row FIFO heads presented to the main instance.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rv[i] = en[i] && (rd_ptr[i] < wr_ptr[i]);
            rd[i] = mem[i][rd_ptr[i][6:0]];
        end
    end

    wb_drain_sched #(.DATA_WIDTH(DW), .OFM_W(8), .OFM_C(2), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .row0_data(rd[0]), .row1_data(rd[1]), .row2_data(rd[2]),
        .row3_data(rd[3]), .row4_data(rd[4]),
        .row0_valid(rv[0]), .row1_valid(rv[1]), .row2_valid(rv[2]),
        .row3_valid(rv[3]), .row4_valid(rv[4]),
        .row0_pop(pop[0]), .row1_pop(pop[1]), .row2_pop(pop[2]),
        .row3_pop(pop[3]), .row4_pop(pop[4]),
        .out_port0(out_port0), .out_port1(out_port1),
        .port0_valid(port0_valid), .port1_valid(port1_valid),
        .out_ready(out_ready), .busy(busy), .pass_done(pass_done),
        .all_done(all_done)
    );

    wb_drain_sched #(.DATA_WIDTH(DW), .OFM_W(1), .OFM_C(1), .CNT_WIDTH(8)) u_dut_w1 (
        .clk(clk), .rst(rst), .start(w1_start),
        .row0_data(wd[0]), .row1_data(wd[1]), .row2_data(wd[2]),
        .row3_data(wd[3]), .row4_data(wd[4]),
        .row0_valid(1'b1), .row1_valid(1'b1), .row2_valid(1'b1),
        .row3_valid(1'b1), .row4_valid(1'b1),
        .row0_pop(w1_pop[0]), .row1_pop(w1_pop[1]), .row2_pop(w1_pop[2]),
        .row3_pop(w1_pop[3]), .row4_pop(w1_pop[4]),
        .out_port0(w1_o0), .out_port1(w1_o1),
        .port0_valid(w1_v0), .port1_valid(w1_v1),
        .out_ready(1'b1), .busy(w1_busy), .pass_done(w1_pd),
        .all_done(w1_ad)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle observation at the falling edge.
    task automatic monitor();
        logic [4:0] p;
        logic [1:0] code;
        exp_t       e;
        p = pop;
        busy_cyc += int'(busy);
        pd_cnt   += int'(pass_done);
        w1_busyc += int'(w1_busy);
        w1_pdc   += int'(w1_pd);
        if (rst) begin
            chk("pops_in_reset", {27'd0, w1_pop, p}, 64'd0);
            sb.delete();
            pop_l   = '0;
            hold    = 1'b0;
            w1_last = 2'd0;
            return;
        end
        // single-column instance: output matches the pair popped last cycle
        if (w1_v0) begin
            case (w1_last)
                2'd1: chk("w1_out01", {w1_o0, w1_o1, w1_v1}, {wd[0], wd[1], 1'b1});
                2'd2: chk("w1_out23", {w1_o0, w1_o1, w1_v1}, {wd[2], wd[3], 1'b1});
                2'd3: chk("w1_out4", {w1_o0, w1_v1}, {wd[4], 1'b0});
                default: begin
                    n_vec++; n_err++;
                    $display("FAIL w1_unexpected_valid: got valid=1 required valid=0");
                end
            endcase
        end
        code = (w1_pop == 5'b00011) ? 2'd1 : (w1_pop == 5'b01100) ? 2'd2 :
               (w1_pop == 5'b10000) ? 2'd3 : 2'd0;
        if (w1_pop != 5'b0) begin
            w1_fires++;
            w1_seq = {w1_seq[3:0], code};
        end
        w1_last = code;
        // held word during a stall
        if (hold) begin
            chk("hold_port0", {port0_valid, out_port0}, {1'b1, hd0});
            chk("hold_port1", {port1_valid, out_port1}, {hv1, hv1 ? hd1 : out_port1});
        end
        if (port0_valid && !out_ready) chk("stall_nopop", p, 5'd0);
        // accepted word vs scoreboard
        if (port0_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_word: got %0h required none", out_port0);
            end else begin
                e = sb.pop_front();
                chk("port0_data", out_port0, e.d0);
                chk("port1_valid", port1_valid, e.v1);
                if (e.v1) chk("port1_data", out_port1, e.d1);
                words++;
            end
        end
        if (p != 5'b0) begin
            chk("pop_legal", ((p == 5'b00011) && rv[0] && rv[1]) ||
                             ((p == 5'b01100) && rv[2] && rv[3]) ||
                             ((p == 5'b10000) && rv[4]), 1);
            if (p[0])      sb.push_back('{d0: rd[0], d1: rd[1], v1: 1'b1});
            else if (p[2]) sb.push_back('{d0: rd[2], d1: rd[3], v1: 1'b1});
            else if (p[4]) sb.push_back('{d0: rd[4], d1: '0, v1: 1'b0});
        end
        hold  = port0_valid && !out_ready;
        hd0   = out_port0;
        hd1   = out_port1;
        hv1   = port1_valid;
        pop_l = p;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) if (pop_l[i]) rd_ptr[i]++;
    endtask

    task automatic load_rows();
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 8; j++) begin
                mem[i][wr_ptr[i][6:0]] = DW'(((i + 1) << 16) | (pass_no << 8) | (j + 1));
                wr_ptr[i]++;
            end
        end
        pass_no++;
    endtask

    task automatic run_pass(input vec_t v);
        int w0;
        load_rows();
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("all_done_cleared_by_start", all_done, 1'b0);
        chk("busy_after_start", busy, 1'b1);
        busy_cyc = 0;
        pd_cnt   = 0;
        w0       = words;
        for (int t = 0; t < 100 && pd_cnt == 0; t++) begin
            out_ready = !(t >= v.stall_at && t < v.stall_at + v.stall_len);
            en[1]     = !(t >= v.skew_at && t < v.skew_at + v.skew_len);
            start     = (t == v.ign_start_at);
            cycle();
        end
        start = 1'b0; out_ready = 1'b1; en = '1;
        repeat (3) cycle();
        chk("busy_cycles", busy_cyc, v.exp_busy);
        chk("pass_done_pulses", pd_cnt, 1);
        chk("word_count", words - w0, 24);
        chk("all_done", all_done, v.exp_all);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{stall_at: -1, stall_len: 0, skew_at: -1, skew_len: 0, ign_start_at: -1, exp_busy: 24, exp_all: 1'b0};
        vt[1] = '{stall_at: 10, stall_len: 3, skew_at: -1, skew_len: 0, ign_start_at: -1, exp_busy: 27, exp_all: 1'b1};
        vt[2] = '{stall_at: -1, stall_len: 0, skew_at: 2,  skew_len: 4, ign_start_at: 5,  exp_busy: 28, exp_all: 1'b0};
        vt[3] = '{stall_at: -1, stall_len: 0, skew_at: -1, skew_len: 0, ign_start_at: 12, exp_busy: 24, exp_all: 1'b0};
        vt[4] = '{stall_at: 20, stall_len: 2, skew_at: -1, skew_len: 0, ign_start_at: -1, exp_busy: 26, exp_all: 1'b1};

        rst = 1'b1; start = 1'b0; out_ready = 1'b1; en = '1; w1_start = 1'b0;
        w1_seq = '0; w1_last = '0; pop_l = '0; hold = 1'b0; hv1 = 1'b0; hd0 = '0; hd1 = '0;
        for (int i = 0; i < 5; i++) begin
            rd_ptr[i] = 0;
            wr_ptr[i] = 0;
            wd[i]     = DW'(32'h0A000 + i * 32'h111);
        end
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_valids", {port0_valid, port1_valid}, 2'b00);
        chk("reset_ports", {out_port0, out_port1}, {DW'(0), DW'(0)});
        chk("reset_flags", {busy, pass_done, all_done}, 3'b000);
        chk("reset_pops", pop, 5'd0);

        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                // reset mid-pass with the channel counter at 1, during P23 col 3
                load_rows();
                start = 1'b1;
                cycle();
                start = 1'b0;
                repeat (11) cycle();
                rst = 1'b1;
                cycle();
                rst = 1'b0;
                chk("midreset_busy", busy, 1'b0);
                chk("midreset_valids", {port0_valid, port1_valid}, 2'b00);
                chk("midreset_flags", {pass_done, all_done}, 2'b00);
                chk("midreset_pops", pop, 5'd0);
            end
            run_pass(vt[i]);
        end

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("idle_reset_all_done", all_done, 1'b0);

        // single-column instance
        w1_fires = 0; w1_pdc = 0; w1_busyc = 0; w1_seq = '0;
        w1_start = 1'b1;
        cycle();
        w1_start = 1'b0;
        repeat (6) cycle();
        chk("w1_fires", w1_fires, 3);
        chk("w1_fire_order", w1_seq, 6'b01_10_11);
        chk("w1_pass_done", w1_pdc, 1);
        chk("w1_busy_cycles", w1_busyc, 3);
        chk("w1_all_done", w1_ad, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
